// File: rtl/prio_scan_enc_if.sv
// Handshake bundle for prio_scan_enc: vector-in channel and index-out channel.
interface prio_scan_enc_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 2) ? $clog2(WIDTH) : 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_none;

    modport master (
        output in_valid, in_vec, mode, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );

    modport slave (
        input  in_valid, in_vec, mode, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );
endinterface

// File: rtl/prio_scan_enc.sv
// Priority scan encoder: emits the highest set bit of an accepted vector (single)
// or every set bit highest-first (scan), one beat per transfer.
module prio_scan_enc #(
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    prio_scan_enc_if.slave   bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] res, res_n;
    logic [WIDTH-1:0] rest, low;
    logic             mode_q, mode_n;
    logic [IDXW-1:0]  hi_idx;
    logic             last;

    // Highest set bit of the residual, plus the residual with that bit removed.
    always_comb begin
        hi_idx = '0;
        rest   = '0;
        low    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (res[i]) begin
                hi_idx = IDXW'(i);
                rest   = res & low;
            end
            low[i] = 1'b1;
        end
    end

    assign last = mode_q ? (rest == '0) : 1'b1;

    // Outputs derive only from registered state, so in_vec never reaches out_*.
    assign bus.in_ready  = en & (state == IDLE);
    assign bus.out_valid = en & (state == EMIT);
    assign bus.out_idx   = (state == EMIT) ? hi_idx : '0;
    assign bus.out_last  = (state == EMIT) & last;
    assign bus.out_none  = (state == EMIT) & (res == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            res    <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_n;
            res    <= res_n;
            mode_q <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        res_n   = res;
        mode_n  = mode_q;
        case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    res_n   = bus.in_vec;
                    mode_n  = bus.mode;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_valid && bus.out_ready) begin
                    if (last) state_n = IDLE;
                    else      res_n   = rest;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_prio_scan_enc.sv
// Scoreboard bench for prio_scan_enc: expected beats queued at accept, checked on transfer.
module tb_prio_scan_enc;
    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    prio_scan_enc_if #(.WIDTH(8)) bus ();
    prio_scan_enc_if #(.WIDTH(5)) b5 ();

    prio_scan_enc #(.WIDTH(8)) u_dut (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus.slave));
    prio_scan_enc #(.WIDTH(5)) u_w5  (.clk(clk), .rst_n(rst_n), .en(en), .bus(b5.slave));

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       none;
    } beat_t;

    beat_t q[$];
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: beats that a vector should produce, highest bit first.
    task automatic push_exp(input logic [7:0] vec, input logic md);
        logic [7:0] left;
        beat_t b;
        left = vec;
        if (vec == 8'h00) begin
            b = '{idx: 3'd0, last: 1'b1, none: 1'b1};
            q.push_back(b);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (left[i]) begin
                    left[i] = 1'b0;
                    b = '{idx: 3'(i), last: (!md || left == 8'h00), none: 1'b0};
                    q.push_back(b);
                    if (!md) break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious", bus.out_valid, 0);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("idx",  bus.out_idx,  e.idx);
                chk("last", bus.out_last, e.last);
                chk("none", bus.out_none, e.none);
            end
        end
    end

    // Drives a vector until accepted; returns on the negedge after accept.
    task automatic send(input logic [7:0] vec, input logic md);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        bus.mode     = md;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept", {31'd0, acc}, 1);
        if (acc) begin
            push_exp(vec, md);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.mode     = ~md;
            bus.in_vec   = 8'($urandom);
            @(negedge clk);
            chk("lat", bus.out_valid, 1);
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit rnd);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) break;
            @(posedge clk); #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        end
        chk("drain", q.size(), 0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        bus.in_valid = 1'b0; bus.in_vec = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
        b5.in_valid  = 1'b0; b5.in_vec  = '0; b5.mode  = 1'b0; b5.out_ready  = 1'b1;
        #3;
        chk("rst_vld",  bus.out_valid, 0);
        chk("rst_rdy",  bus.in_ready,  1);
        chk("rst_idx",  bus.out_idx,   0);
        chk("rst_last", bus.out_last,  0);
        chk("rst_none", bus.out_none,  0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single mode, highest bit only, ready again after one beat
        send(8'b0010_1100, 1'b0);
        @(negedge clk);
        chk("rdy_after", bus.in_ready, 1);
        drain(0);

        // Scan mode, three consecutive beats
        send(8'b1000_0101, 1'b1);
        @(negedge clk); chk("scan_b2", bus.out_valid, 1);
        @(negedge clk); chk("scan_b3", bus.out_valid, 1);
        drain(0);

        send(8'h00, 1'b0); drain(0);
        send(8'h00, 1'b1); drain(0);

        // Backpressure holds the first beat
        bus.out_ready = 1'b0;
        send(8'b0100_0010, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_idx",  bus.out_idx,  6);
            chk("bp_last", bus.out_last, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain(0);

        // Enable low mid-scan freezes everything
        send(8'b1000_0101, 1'b1);
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("en_vld", bus.out_valid, 0);
            chk("en_rdy", bus.in_ready,  0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("resume", bus.out_idx, 2);
        drain(0);

        // Asynchronous reset mid-scan discards the rest
        send(8'b1000_0101, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  bus.out_valid, 0);
        chk("arst_rdy",  bus.in_ready,  1);
        chk("arst_idx",  bus.out_idx,   0);
        chk("arst_last", bus.out_last,  0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", bus.in_ready,  1);
        chk("rel_vld", bus.out_valid, 0);
        drain(0);

        // Non-power-of-two width
        @(posedge clk); #1;
        b5.in_valid = 1'b1; b5.in_vec = 5'b10000; b5.mode = 1'b0;
        @(negedge clk); chk("w5_rdy", b5.in_ready, 1);
        @(posedge clk); #1;
        b5.in_valid = 1'b0;
        @(negedge clk);
        chk("w5_vld",  b5.out_valid, 1);
        chk("w5_idx",  b5.out_idx,   4);
        chk("w5_last", b5.out_last,  1);
        chk("w5_none", b5.out_none,  0);
        @(negedge clk);
        chk("w5_done", b5.in_ready, 1);

        // Random vectors, modes and backpressure
        for (int n = 0; n < 25; n++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)));
            drain(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/prio_scan_enc.md
PRIO_SCAN_ENC -- requirements
Module: prio_scan_enc

Interface
REQ-001 Parameter WIDTH, default 8: request vector width; legal range 2..64, power of two not required.
REQ-002 Parameter IDXW, default $clog2(WIDTH), minimum 1: output index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  block enable; low freezes all internal state.
REQ-006 in_valid  input  1  in_vec/mode present.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 in_vec  input  WIDTH  request vector; bit WIDTH-1 has highest priority.
REQ-009 mode  input  1  0 = single (highest set bit only); 1 = scan (every set bit, highest first).
REQ-010 out_valid  output  1  out_idx/out_last/out_none valid.
REQ-011 out_ready  input  1  downstream consumes the current beat.
REQ-012 out_idx  output  IDXW  bit position of the emitted request.
REQ-013 out_last  output  1  final beat for the accepted vector.
REQ-014 out_none  output  1  accepted vector was all-zero.

Function
REQ-015 Two states, IDLE and EMIT, SHALL be used; reset state IDLE.
REQ-016 in_ready SHALL equal en AND (state == IDLE).
REQ-017 Accept = in_valid & in_ready: latch in_vec into the residual register, latch mode, go to EMIT.
REQ-018 Latency: first out_valid SHALL assert the cycle after accept; there is no combinational path from in_vec to out_*.
REQ-019 out_valid SHALL equal en AND (state == EMIT).
REQ-020 A beat transfers when out_valid & out_ready are both high in the same cycle.
REQ-021 out_idx SHALL be the index of the highest set bit of the residual register.
REQ-022 out_idx SHALL be zero-extended to IDXW bits.
REQ-023 Scan mode, per transfer: clear the emitted bit in the residual register; the next beat follows in the next cycle.
REQ-024 out_last SHALL be 1 when the residual register, with the current bit cleared, is zero (scan), and always 1 in single mode.
REQ-025 On transfer of a beat with out_last = 1, the block SHALL return to IDLE; in_ready rises the following cycle.
REQ-026 All-zero vector, either mode: exactly one beat with out_none = 1, out_idx = 0, out_last = 1; otherwise out_none = 0.
REQ-027 Backpressure: while out_valid & !out_ready, out_idx, out_last and out_none SHALL hold stable and no bit is cleared.
REQ-028 en low: no accept, no transfer, no state or residual change; out_idx/out_last/out_none retain their values; the scan resumes unchanged when en returns high.
REQ-029 A mode change after accept SHALL have no effect until the next accept.
REQ-030 Throughput: one beat per cycle in scan mode with out_ready held high; one vector per (set bits + 1) cycles.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, clear the residual and mode registers, and drive out_valid = 0, out_idx = 0, out_last = 0, out_none = 0.
REQ-032 in_ready SHALL equal en while rst_n is low.
REQ-033 Reset mid-scan SHALL discard the remaining bits; no beat is emitted for them after release.
REQ-034 Reset release is synchronous to clk; the first accept is possible on the first rising edge with rst_n high.

Verification
REQ-035 WIDTH=8, mode=0, in_vec=8'b0010_1100, out_ready=1 -> one beat the cycle after accept: idx=5, last=1, none=0; in_ready high the next cycle.
REQ-036 WIDTH=8, mode=1, in_vec=8'b1000_0101, out_ready=1 -> beats idx 7, 2, 0 on consecutive cycles; last=1 only on idx 0.
REQ-037 in_vec=0, either mode -> single beat none=1, idx=0, last=1.
REQ-038 mode=1, in_vec=8'b0100_0010, out_ready low for 3 cycles on the first beat -> idx=6 held stable; then beats idx 6 and 1, none lost or duplicated.
REQ-039 mode=1 mid-scan: en low for 2 cycles -> out_valid=0 and in_ready=0; on en high, resumes at the same idx.
REQ-040 rst_n pulsed low mid-scan -> out_valid drops without waiting for clk; after release, in_ready=1 and no stale beats. WIDTH=5, in_vec=5'b10000 -> idx=3'd4, last=1.
